// File: rtl/sum_stream_receiver.sv
// sum_stream_receiver: credit-granting capture buffer for a valid-only result stream, drained over ready/valid.
module sum_stream_receiver #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     issue_ready,
  input  logic                     issue,
  input  logic                     v_in,
  input  logic [WIDTH-1:0]         d_in,
  output logic                     m_valid,
  output logic [WIDTH-1:0]         m_data,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err_issue,
  output logic                     err_overflow,
  output logic                     err_spurious
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d, inflight_q, inflight_d;
  logic [AW+1:0] reserved;
  logic err_issue_q, err_issue_d, err_overflow_q, err_overflow_d, err_spurious_q, err_spurious_d;
  logic push, pop, take, ret;
  // Credits come only from registered state, so issue_ready has no input-to-output path.
  always_comb begin
    reserved = {1'b0, inflight_q} + {1'b0, count_q};
    issue_ready = reserved < {1'b0, FULL};
    m_valid = count_q != '0;
    m_data = mem[rd_ptr_q];
    pop = m_valid & m_ready;
    push = v_in & ((count_q != FULL) | pop);
    take = issue & issue_ready;
    ret = v_in & (inflight_q != '0);
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d = (push & ~pop) ? count_q + ONE : (pop & ~push) ? count_q - ONE : count_q;
    inflight_d = (take & ~ret) ? inflight_q + ONE : (ret & ~take) ? inflight_q - ONE : inflight_q;
    err_issue_d = err_issue_q | (issue & ~issue_ready);
    err_overflow_d = err_overflow_q | (v_in & ~push);
    err_spurious_d = err_spurious_q | (v_in & (inflight_q == '0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      inflight_q <= '0;
      err_issue_q <= 1'b0;
      err_overflow_q <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      err_issue_q <= err_issue_d;
      err_overflow_q <= err_overflow_d;
      err_spurious_q <= err_spurious_d;
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr_q] <= d_in;
  assign level = count_q;
  assign inflight = inflight_q;
  assign err_issue = err_issue_q;
  assign err_overflow = err_overflow_q;
  assign err_spurious = err_spurious_q;
endmodule

// File: doc/sum_stream_receiver.md
# sum_stream_receiver

Receive-side endpoint for the fixed-latency, valid-only adder result stream. No backpressure is possible upstream, so the block grants issue credits to the operand source, captures every returning result into a DEPTH-entry buffer, and presents the results downstream on a ready/valid interface. It sits between the adder output registers and any consumer that may stall, so no result is ever dropped.

## Interface

Parameters:
- WIDTH, 16: result data width.
- DEPTH, 8: buffer entries. Power of two, ≥2. Must be ≥ the adder's issue-to-result latency for full throughput.

Ports (clock and reset first):
- clk  in  1  single clock; all state on posedge.
- rst  in  1  reset; synchronous, active-high.
- issue_ready  out  1  a credit is available; the source may launch one operation this cycle.
- issue  in  1  the source launched one operation into the adder this cycle.
- v_in  in  1  a result is valid from the adder this cycle.
- d_in  in  WIDTH  result data; qualified by v_in.
- m_valid  out  1  downstream data valid.
- m_data  out  WIDTH  head-of-buffer result.
- m_ready  in  1  downstream accepts.
- level  out  $clog2(DEPTH)+1  entries currently stored.
- inflight  out  $clog2(DEPTH)+1  issued operations not yet returned.
- err_issue  out  1  sticky: issue asserted while issue_ready=0.
- err_overflow  out  1  sticky: v_in arrived with the buffer full and no pop.
- err_spurious  out  1  sticky: v_in arrived with inflight=0.

## Operation

- Storage: circular buffer mem[DEPTH], with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and count (= level) of $clog2(DEPTH)+1 bits.
- Push: v_in=1 and (count<DEPTH or pop) writes d_in at wr_ptr, then wr_ptr+1.
- Pop: m_valid & m_ready, then rd_ptr+1.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Full buffer with simultaneous pop and v_in: push is accepted; no error.
- Output is first-word-fall-through:
  - m_valid = (count≠0)
  - m_data = mem[rd_ptr]
  - m_data is don't-care while m_valid=0.
- Credits:
  - reserved = inflight + count.
  - issue_ready = (reserved < DEPTH), decoded from registers only. There is no combinational path from issue, v_in or m_ready.
- inflight update:
  - issue & issue_ready: +1
  - v_in with inflight>0: −1
  - both in the same cycle: unchanged
- issue while issue_ready=0: the issue is ignored (no credit taken) and err_issue is set.
- v_in with inflight=0: err_spurious is set. Data is still pushed if space allows, and inflight stays 0.
- v_in with count=DEPTH and no pop: data is dropped, pointers and count are unchanged, and err_overflow is set.
- Error flags clear only on rst.
- No state machine beyond the pointer/counter datapath. The block is either idle (reserved=0), active, or saturated (reserved=DEPTH).

## Timing

- Reset values:
  - m_valid=0, issue_ready=1 (DEPTH≥1), level=0, inflight=0, all err_*=0.
  - Pointers are 0; mem contents are not reset.
- rst asserted mid-operation: everything returns to reset values on the next edge, and buffered results are discarded.
- Results still in the adder after reset will arrive as spurious. The system must reset the adder in the same cycle.
- Push latency: v_in sampled at edge N → m_valid=1 and m_data=d_in in cycle N+1.
- Pop: on the edge where m_valid & m_ready, the next entry (if any) appears in the following cycle. Sustained throughput is 1 per cycle.
- Credit return: a pop at edge N raises issue_ready no earlier than cycle N+1.
- Issue counts at the edge where issue=1; issue_ready reflects it from cycle N+1.
- Guarantee: if the source obeys issue_ready, then inflight+count ≤ DEPTH always, and err_overflow can never set.

## Test plan

- Reset, then idle → issue_ready=1, m_valid=0, level=0, inflight=0, all err_*=0.
- DEPTH=8, m_ready=0, issue 8 ops, return results 0x0001..0x0008 three cycles later:
  - issue_ready falls in the cycle after the 8th issue.
  - level=8, inflight=0.
  - then m_ready=1 drains 0x0001..0x0008 in order, one per cycle.
  - issue_ready returns in the cycle after the first pop.
- Streaming: issue every cycle, results returning every cycle with latency 3, m_ready=1 → one result per cycle in order, level≤1, no errors, issue_ready stays 1.
- Buffer full with m_ready=1, and v_in=1 with d_in=0xBEEF in the same cycle → accepted, level stays 8, 0xBEEF appears last, err_overflow=0.
- Error injection:
  - issue while issue_ready=0 → err_issue=1, inflight unchanged.
  - v_in with inflight=0 → err_spurious=1.
  - forced v_in at level=8, m_ready=0 → err_overflow=1, and 0xDEAD is never output.
- Assert rst with level=5 and inflight=2 → next cycle: m_valid=0, level=0, inflight=0, errors cleared; the pointer-wrap path still works on refill.
